final_reduce_core: RTL
======================

# final_reduce_core

Parametrised byte-stream reduction engine for the FINAL design, the next generation of the single-mode FINAL core. It owns a 32-bit-word local memory that the host loads through a word port, then reduces a programmable byte range under a Go/Done handshake in one of four modes (sum, max, min, sum of squares). The result uses saturating arithmetic with a sticky overflow flag. It sits directly behind the host bus in FINAL_Top, replacing the fixed-range core.

## Interface
- A_WIDTH, 8, byte-address width; memory holds 2**(A_WIDTH-2) words of 32 bits.
- R_WIDTH, 20, result width; must be ≥ 16.
- Clk  in  1  sole clock; all logic on rising edge.
- Rst  in  1  reset, synchronous, active-high; clears FSM/outputs, memory contents preserved.
- M_enb  in  1  host memory enable.
- M_web  in  1  host write enable (with M_enb).
- M_Addr  in  A_WIDTH-2  host word address.
- M_di32  in  32  host write data.
- M_do32  out  32  host read data, registered.
- Go  in  1  start request, sampled in IDLE only.
- Mode  in  2  0 SUM, 1 MAX, 2 MIN, 3 SQSUM; latched with Go.
- Start  in  A_WIDTH  first byte address; latched with Go.
- Len  in  A_WIDTH+1  byte count, 0..2**A_WIDTH; latched with Go.
- Busy  out  1  run in progress.
- Done  out  1  one-cycle completion pulse.
- Result  out  R_WIDTH  reduction result, held until next accepted Go.
- Ovf  out  1  saturation occurred in current/last run.

## Operation
- Byte address b maps to word b>>2, lane b[1:0]; lane 0 = bits 7:0 (little-endian).
- Host access: M_enb&M_web writes word; M_enb&!M_web reads, M_do32 valid next cycle. While Busy, host writes are ignored and M_do32 holds its value.
- FSM: IDLE → (Go) RUN → DRAIN → DONE → IDLE. Len=0: IDLE → DRAIN → DONE, issuing no reads.
- RUN issues one byte address per cycle, Start, Start+1, …, wrapping modulo 2**A_WIDTH, for Len cycles; DRAIN absorbs the final read latency.
- Accumulator init on Go: SUM/SQSUM 0, MAX 0x00, MIN 0xFF. Each returned byte updates it. SQSUM adds byte² (16-bit).
- SUM/SQSUM saturate at 2**R_WIDTH-1 and set Ovf; Ovf is sticky until the next accepted Go. MAX/MIN never set Ovf.
- Len=0: Result = 0 in all modes.
- Go while Busy: ignored. Go in the DONE cycle: ignored.
- Rst at any point: on the next edge FSM=IDLE, Busy=0, Done=0, Result=0, Ovf=0, M_do32=0; no Done pulse for the aborted run.

## Timing
- Reset values: Busy 0, Done 0, Result 0, Ovf 0, M_do32 0.
- Go sampled high at edge t: Busy=1 from t+1 through the Done cycle inclusive.
- Read addresses issued cycles t+1..t+Len; sync memory returns data one cycle later; accumulation happens cycles t+2..t+Len+1.
- Done=1 for exactly cycle t+Len+2, so Len=0 gives t+2. Result/Ovf are final in that cycle and stable afterward.
- Earliest next Go is accepted in the cycle after Done.

## Structure
- Shared package final_pkg: mode encodings (MODE_SUM/MAX/MIN/SQSUM), WORD_W=32, BYTE_W=8, FSM state encoding.
- Sub-module final_mem: 2**(A_WIDTH-2)×32 sync-read/sync-write RAM with a registered byte-lane select. Port mux (host vs core, selected by Busy) lives in final_reduce_core.

## Test plan
- Load ramp (byte b = b), SUM, Start=0, Len=256 → Result 0x07F80, Ovf=0, Done exactly 258 cycles after Go.
- Ramp, SUM, Start=254, Len=4 (wrap: 254,255,0,1) → Result 0x001FE; MIN, Start=16, Len=8 → 0x00010; MAX, Start=250, Len=10 → 0x000FF.
- All bytes 0xFF, SQSUM, Len=256 → Result 0xFFFFF, Ovf=1; then SUM, Len=1 → Result 0x000FF, Ovf=0.
- Len=0, any mode → Done at Go+2, Result 0, no memory reads.
- Go during Busy and host write of 0xDEADBEEF to word 0 during Busy → both ignored; run result unchanged, later read of word 0 returns the original ramp word 0x03020100.
- Rst asserted 5 cycles into a Len=256 run → next cycle Busy=0, Result=0, no Done pulse; a new SUM Len=256 run → 0x07F80 (memory retained).

Source files
------------

// File: rtl/final_pkg.sv
// Shared encodings for the FINAL reduction engine: widths, modes, FSM states.
package final_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    MODE_SUM   = 2'd0,
    MODE_MAX   = 2'd1,
    MODE_MIN   = 2'd2,
    MODE_SQSUM = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [2*BYTE_W-1:0] byte_sq(input logic [BYTE_W-1:0] b);
    logic [2*BYTE_W-1:0] w;
    w = {{BYTE_W{1'b0}}, b};
    return w * w;
  endfunction

endpackage

// File: rtl/final_mem.sv
// Single-port word RAM, sync write / sync read, with a host word register
// and a core byte path whose lane select is registered alongside the word.
module final_mem
  import final_pkg::*;
#(
  parameter int A_WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               we,
  input  logic [A_WIDTH-3:0] addr,
  input  logic [WORD_W-1:0]  wdata,
  input  logic               word_ld,
  input  logic               byte_ld,
  input  logic [1:0]         lane,
  output logic [WORD_W-1:0]  word_q,
  output logic [BYTE_W-1:0]  byte_q
);

  localparam int DEPTH = 2 ** (A_WIDTH - 2);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] core_word_q;
  logic [1:0]        lane_q;

  always_ff @(posedge Clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Host read data survives core traffic: only host reads reload it.
  always_ff @(posedge Clk) begin
    if (Rst) word_q <= '0;
    else if (word_ld) word_q <= mem[addr];
  end

  always_ff @(posedge Clk) begin
    if (byte_ld) begin
      core_word_q <= mem[addr];
      lane_q      <= lane;
    end
  end

  assign byte_q = core_word_q[{lane_q, 3'b000} +: BYTE_W];

endmodule

// File: rtl/final_reduce_core.sv
// Byte-range reduction engine (sum/max/min/sum of squares) over a host-loaded
// word memory, with saturating result and sticky overflow.
//
// state    | meaning
// ST_IDLE  | waiting for Go; host owns the memory port
// ST_RUN   | issuing one byte read per cycle, Len cycles
// ST_DRAIN | last read data returning and being accumulated
// ST_DONE  | Done pulse; Result/Ovf final
module final_reduce_core
  import final_pkg::*;
#(
  parameter int A_WIDTH = 8,
  parameter int R_WIDTH = 20
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               M_enb,
  input  logic               M_web,
  input  logic [A_WIDTH-3:0] M_Addr,
  input  logic [WORD_W-1:0]  M_di32,
  output logic [WORD_W-1:0]  M_do32,
  input  logic               Go,
  input  logic [1:0]         Mode,
  input  logic [A_WIDTH-1:0] Start,
  input  logic [A_WIDTH:0]   Len,
  output logic               Busy,
  output logic               Done,
  output logic [R_WIDTH-1:0] Result,
  output logic               Ovf
);

  state_e               state_q, state_d;
  mode_e                mode_q;
  logic [A_WIDTH-1:0]   addr_q;
  logic [A_WIDTH:0]     cnt_q;
  logic                 rd_vld_q;
  logic [R_WIDTH-1:0]   acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 go_acc;
  logic [BYTE_W-1:0]    rbyte;
  logic [2*BYTE_W-1:0]  term;
  logic [R_WIDTH:0]     sum_w;
  logic                 mem_we;
  logic                 mem_word_ld;
  logic [A_WIDTH-3:0]   mem_addr;

  assign Busy   = (state_q != ST_IDLE);
  assign Done   = (state_q == ST_DONE);
  assign go_acc = (state_q == ST_IDLE) && Go;

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (Go) state_d = (Len == '0) ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (cnt_q == {{A_WIDTH{1'b0}}, 1'b1}) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Byte address walks and wraps naturally at 2**A_WIDTH; cnt_q is the terminal-count timer.
  always_ff @(posedge Clk) begin
    if (go_acc) begin
      addr_q <= Start;
      cnt_q  <= Len;
      mode_q <= mode_e'(Mode);
    end else if (state_q == ST_RUN) begin
      addr_q <= addr_q + 1'b1;
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) rd_vld_q <= 1'b0;
    else     rd_vld_q <= (state_q == ST_RUN);
  end

  assign mem_we      = M_enb & M_web & ~Busy;
  assign mem_word_ld = M_enb & ~M_web & ~Busy;
  assign mem_addr    = Busy ? addr_q[A_WIDTH-1:2] : M_Addr;

  final_mem #(.A_WIDTH(A_WIDTH)) u_mem (
    .Clk     (Clk),
    .Rst     (Rst),
    .we      (mem_we),
    .addr    (mem_addr),
    .wdata   (M_di32),
    .word_ld (mem_word_ld),
    .byte_ld (state_q == ST_RUN),
    .lane    (addr_q[1:0]),
    .word_q  (M_do32),
    .byte_q  (rbyte)
  );

  always_comb begin
    term  = (mode_q == MODE_SQSUM) ? byte_sq(rbyte) : {{BYTE_W{1'b0}}, rbyte};
    sum_w = {1'b0, acc_q} + {{(R_WIDTH+1-2*BYTE_W){1'b0}}, term};
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (rd_vld_q) begin
      case (mode_q)
        MODE_SUM, MODE_SQSUM: begin
          if (sum_w[R_WIDTH]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum_w[R_WIDTH-1:0];
          end
        end
        MODE_MAX: if (rbyte > acc_q[BYTE_W-1:0]) acc_d = {{(R_WIDTH-BYTE_W){1'b0}}, rbyte};
        MODE_MIN: if (rbyte < acc_q[BYTE_W-1:0]) acc_d = {{(R_WIDTH-BYTE_W){1'b0}}, rbyte};
        default: ;
      endcase
    end
  end

  // An empty range reports 0 even for MIN, hence the Len check on init.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (go_acc) begin
      ovf_q <= 1'b0;
      if (Len != '0 && mode_e'(Mode) == MODE_MIN)
        acc_q <= {{(R_WIDTH-BYTE_W){1'b0}}, {BYTE_W{1'b1}}};
      else
        acc_q <= '0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign Result = acc_q;
  assign Ovf    = ovf_q;

endmodule
